// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI slave responder.
//   spi_slv_state_t : responder FSM states
//   DEF_DATA_W      : default frame width
//   DEF_IDLE_PAT    : default response sent when no word was loaded
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} spi_slv_state_t;
    localparam int DEF_DATA_W = 12;
    localparam logic [DEF_DATA_W-1:0] DEF_IDLE_PAT = 12'hFFF;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer plus a third stage for edge detection.
//   clk, rst_n : system clock, async active-low reset (chain resets to RST_VAL)
//   din        : asynchronous input pin
//   level      : synchronized level (2 clk latency)
//   rise, fall : one-clk pulses on synchronized edges
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= {3{RST_VAL}};
        else        sr <= {sr[1:0], din};
    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI slave (CPOL=0, LSB first) with load/receive handshake.
//   clk, rst_n          : system clock, async active-low reset
//   sclk, cs, mosi      : SPI pins from the master (async to clk, cs active low)
//   miso, miso_oe       : slave data out and its enable (high while a frame is active)
//   tx_data/valid/ready : response word load handshake (one-word buffer)
//   rx_data, rx_valid   : last received word and its completion pulse
//   underrun, frame_err : pulses for "no word loaded" and "cs rose early"
//   frame_cnt           : completed-frame counter, present only with SPI_FRAME_CNT_EN defined
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_PAT = DEF_IDLE_PAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    output logic              frame_err
`ifdef SPI_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);
    localparam int CW = $clog2(DATA_W + 1);
    spi_slv_state_t    state, state_nx;
    logic              sclk_unused, sclk_rise, sclk_fall;
    logic              cs_lvl, cs_rise, cs_fall;
    logic [1:0]        mosi_sr;
    logic [DATA_W-1:0] tx_buf, shift_tx, shift_rx;
    logic              full, load, start, last_rise;
    logic [CW-1:0]     count;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(cs),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    // mosi only needs its level, so a bare 2-FF chain is enough
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mosi_sr <= 2'b00;
        else        mosi_sr <= {mosi_sr[0], mosi};

    assign tx_ready  = !full;
    assign load      = tx_valid && tx_ready;
    assign start     = (state == IDLE) && cs_fall;
    assign last_rise = (state == SHIFT) && sclk_rise && (count == CW'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // a final sclk rise wins over a simultaneous cs rise; WAIT_CS leaves on the cs level
    // so a cs rise that landed during DONE is not lost
    always_comb
        state_nx = (state == IDLE)  ? (cs_fall ? SHIFT : IDLE) :
                   (state == SHIFT) ? (last_rise ? DONE : (cs_rise ? IDLE : SHIFT)) :
                   (state == DONE)  ? WAIT_CS :
                                      (cs_lvl ? IDLE : WAIT_CS);

    always_comb
        miso_oe = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            full      <= 1'b0;
            tx_buf    <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
            count     <= '0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            // a load coinciding with frame start is kept for the next frame
            full      <= load || (full && !start);
            if (load) tx_buf <= tx_data;
            if (start) begin
                shift_tx <= full ? tx_buf : IDLE_PAT;
                miso     <= full ? tx_buf[0] : IDLE_PAT[0];
                underrun <= !full;
                count    <= '0;
            end
            if (state == SHIFT && sclk_rise) begin
                shift_rx <= {mosi_sr[1], shift_rx[DATA_W-1:1]};
                count    <= count + 1'b1;
            end
            if (state == SHIFT && sclk_fall && count < CW'(DATA_W)) begin
                shift_tx <= shift_tx >> 1;
                miso     <= shift_tx[1];
            end
            if (state == SHIFT && cs_rise && !last_rise) begin
                frame_err <= 1'b1;
                miso      <= 1'b0;
            end
            if (state == DONE) begin
                rx_data  <= shift_rx;
                rx_valid <= 1'b1;
            end
            if (state == WAIT_CS && cs_lvl) miso <= 1'b0;
        end

`ifdef SPI_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)              frame_cnt <= '0;
        else if (state == DONE)  frame_cnt <= frame_cnt + 16'd1;
`endif
endmodule
